snail_bit_serializer: RTL and testbench
=======================================

Name: snail_bit_serializer

Overview:
Upstream feeder for the snail Mealy recognizer. Accepts parallel test/stimulus words over a valid/ready handshake and streams them MSB-first, one bit per clock, onto the recognizer's serial input A. A one-entry holding buffer allows back-to-back words with no idle bit between them. A clock-enable pauses the stream without losing bits.

Parameters:
WIDTH, 24, maximum word length in bits
LEN_W, $clog2(WIDTH+1), width of the length field

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
in_valid  input  1  producer offers in_data/in_len this cycle
in_ready  output  1  block can accept a word this cycle
in_data  input  WIDTH  word to serialize, bits right-aligned (bit 0 sent last)
in_len  input  LEN_W  number of bits to send; 0 or >WIDTH means WIDTH
en  input  1  shift enable; 0 freezes the stream
A  output  1  serial bit to recognizer (its A input)
A_valid  output  1  A carries a real stream bit this cycle
last  output  1  high while the final bit of the current word is on A
busy  output  1  shift register or holding buffer occupied
bit_idx  output  LEN_W  index within in_data of the bit currently on A

Behaviour:
- Storage: shift register (data, remaining count) plus one-entry holding buffer (data, len, pend_valid).
- States: IDLE (no active word), SHIFT (active word on A).
- Reset: on any edge with rst=1, state<=IDLE, pend_valid<=0, count<=0. Outputs in/after reset cycle: A=0, A_valid=0, last=0, busy=0, bit_idx=0. in_ready=0 while rst=1. Reset mid-word discards the active and the buffered word, with no partial completion.
- Accept: a word is accepted at an edge where in_valid && in_ready. in_ready = !rst && !pend_valid, combinational from registered state.
- Routing of an accepted word:
  - Goes straight into the shift register if state=IDLE, or if state=SHIFT && last && en at that edge.
  - Otherwise it goes into the holding buffer.
- Length: effective len L = (in_len==0 || in_len>WIDTH) ? WIDTH : in_len.
- Latency: word accepted at edge k into an idle block puts bit in_data[L-1] on A during cycle k+1.
- Shifting:
  - In SHIFT with en=1, each edge advances to the next lower bit.
  - With en=0, A, A_valid, bit_idx and last hold their values.
  - A_valid=1 throughout SHIFT, including stalled cycles.
- Outputs:
  - A and bit_idx are registered, not combinational from in_data.
  - last=1 in SHIFT when bit_idx==0.
  - busy = (state==SHIFT) || pend_valid.
- End of word, at an edge with last && en:
  - If pend_valid: load buffer into shift register and clear pend_valid. The next word's MSB is on A the very next cycle, with no gap.
  - Else if a word is accepted that edge: load it directly, also with no gap.
  - Else: go to IDLE with A=0, A_valid=0, bit_idx=0.
- Buffer-full: while pend_valid=1, in_ready=0. A new word cannot be accepted on the same edge the buffer drains; it is accepted one cycle later at the earliest.
- IDLE with en=0: an accepted word still loads. Its first bit appears on A and holds until en=1.
- L=1: a single-cycle word; last=1 on its only bit.

Test Plan:
- Single word: in_data=24'hE34EED, in_len=0, en=1, accepted at edge 0. Required: A over cycles 1..24 = 1,1,1,0,0,0,1,1,0,1,0,0,1,1,1,0,1,1,1,0,1,1,0,1; A_valid=1 and bit_idx 23→0 over those cycles; last=1 only at cycle 24; cycle 25 A_valid=0, busy=0.
- Back-to-back: word1 8'hA5 (L=8), word2 4'b0110 (L=4) offered consecutively. Required: word2 buffered with in_ready=0 after it; A = 1,0,1,0,0,1,0,1,0,1,1,0 over 12 consecutive cycles with no gap; last at cycles 8 and 12.
- Stall: during the 24'hE34EED stream, hold en=0 for 3 cycles at bit_idx=10. Required: A and bit_idx frozen at bit 10 for 4 cycles total; stream then resumes at bit 9; total duration 27 cycles.
- Length edge cases: in_len=1 with data bit0=1 gives one cycle A=1, last=1. in_len=31 (>24) is treated as 24 bits.
- Reset mid-operation: assert rst for 1 cycle at bit_idx=12 with a buffered word present. Required: the next cycle shows A=0, A_valid=0, busy=0, in_ready=1; the buffered word is never emitted.
- Backpressure: offer 3 words with in_valid held high. Required: the third word waits with in_ready=0 until word1's last edge has passed; it is accepted the cycle after the buffer drains, and all three stream in order with no dropped or duplicated bits.

Source files
------------

// File: rtl/snail_bit_serializer_if.sv
// Word-input handshake of the snail bit serializer: the producer offers a
// right-aligned word plus its bit count, the serializer answers with ready.
interface snail_bit_serializer_if #(
   parameter int WIDTH = 24,
   parameter int LEN_W = $clog2(WIDTH + 1)
) ();
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic [LEN_W-1:0] in_len;

   modport master (
      output in_valid,
      output in_data,
      output in_len,
      input  in_ready
   );

   modport slave (
      input  in_valid,
      input  in_data,
      input  in_len,
      output in_ready
   );
endinterface

// File: rtl/snail_bit_serializer.sv
// MSB-first parallel-to-serial feeder for the snail recognizer's A input,
// with a one-word holding buffer so consecutive words stream without a gap.
module snail_bit_serializer #(
   parameter int WIDTH = 24,
   parameter int LEN_W = $clog2(WIDTH + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   snail_bit_serializer_if.slave in_if,
   input  logic                  en,
   output logic                  A,
   output logic                  A_valid,
   output logic                  last,
   output logic                  busy,
   output logic [LEN_W-1:0]      bit_idx
);

   typedef enum logic {
      S_IDLE,
      S_SHIFT
   } state_e;

   typedef logic [WIDTH-1:0] word_t;
   typedef logic [LEN_W-1:0] len_t;

   state_e state_q, state_d;
   word_t  data_q, data_d;
   len_t   idx_q, idx_d;
   logic   a_q, a_d;
   logic   pend_valid_q, pend_valid_d;
   word_t  pend_data_q, pend_data_d;
   len_t   pend_len_q, pend_len_d;

   logic   accept;
   logic   stream_end;
   logic   load_en;
   word_t  load_data;
   len_t   load_len;
   len_t   in_len_eff;

   function automatic logic bit_at(input word_t w, input len_t i);
      word_t s;
      s = w >> i;
      return s[0];
   endfunction

   // A length of zero or anything beyond WIDTH means a full-width word.
   assign in_len_eff = (in_if.in_len == '0 || in_if.in_len > len_t'(WIDTH))
                     ? len_t'(WIDTH) : in_if.in_len;

   assign in_if.in_ready = !rst && !pend_valid_q;
   assign accept         = in_if.in_valid && in_if.in_ready;
   assign last           = (state_q == S_SHIFT) && (idx_q == '0);
   assign stream_end     = last && en;

   assign A       = a_q;
   assign A_valid = (state_q == S_SHIFT);
   assign bit_idx = idx_q;
   assign busy    = (state_q == S_SHIFT) || pend_valid_q;

   // Pick what, if anything, enters the shift register on this edge.
   always_comb begin
      load_en   = 1'b0;
      load_data = in_if.in_data;
      load_len  = in_len_eff;
      if (state_q == S_IDLE) begin
         load_en = accept;
      end else if (stream_end) begin
         if (pend_valid_q) begin
            load_en   = 1'b1;
            load_data = pend_data_q;
            load_len  = pend_len_q;
         end else begin
            load_en = accept;
         end
      end
   end

   // NOTE: every signal driven here gets a default first, so no path leaves
   // one unassigned and no latch is inferred.
   always_comb begin
      state_d      = state_q;
      data_d       = data_q;
      idx_d        = idx_q;
      a_d          = a_q;
      pend_valid_d = pend_valid_q;
      pend_data_d  = pend_data_q;
      pend_len_d   = pend_len_q;

      if (load_en) begin
         state_d = S_SHIFT;
         data_d  = load_data;
         idx_d   = load_len - len_t'(1);
         a_d     = bit_at(load_data, load_len - len_t'(1));
      end else if (stream_end) begin
         state_d = S_IDLE;
         idx_d   = '0;
         a_d     = 1'b0;
      end else if (state_q == S_SHIFT && en) begin
         idx_d = idx_q - len_t'(1);
         a_d   = bit_at(data_q, idx_q - len_t'(1));
      end

      // The buffer drains on a word boundary and fills with any accepted
      // word that could not go straight into the shift register.
      if (stream_end && pend_valid_q) begin
         pend_valid_d = 1'b0;
      end
      if (accept && !load_en) begin
         pend_valid_d = 1'b1;
         pend_data_d  = in_if.in_data;
         pend_len_d   = in_len_eff;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples its _d value from before this edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         idx_q        <= '0;
         a_q          <= 1'b0;
         pend_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         a_q          <= a_d;
         pend_valid_q <= pend_valid_d;
      end
   end

   // NOTE: payload registers are only read while state/pend_valid mark them
   // live, so they carry no reset.
   always_ff @(posedge clk) begin
      data_q      <= data_d;
      pend_data_q <= pend_data_d;
      pend_len_q  <= pend_len_d;
   end

   a_last_needs_valid: assert property (@(posedge clk) disable iff (rst)
      last |-> A_valid);
   a_idle_is_quiet: assert property (@(posedge clk) disable iff (rst)
      !A_valid |-> (!A && bit_idx == '0));

endmodule

// File: tb/tb_snail_bit_serializer.sv
// Self-checking bench: directed scenarios plus random traffic, all compared
// each cycle against a queue-of-words model of the serial stream.
module tb_snail_bit_serializer;
   localparam int WIDTH = 24;
   localparam int LEN_W = $clog2(WIDTH + 1);

   logic             clk = 1'b0;
   logic             rst;
   logic             en;
   logic             A;
   logic             A_valid;
   logic             last;
   logic             busy;
   logic [LEN_W-1:0] bit_idx;

   snail_bit_serializer_if #(.WIDTH(WIDTH), .LEN_W(LEN_W)) bus ();

   snail_bit_serializer #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
      .clk     (clk),
      .rst     (rst),
      .in_if   (bus),
      .en      (en),
      .A       (A),
      .A_valid (A_valid),
      .last    (last),
      .busy    (busy),
      .bit_idx (bit_idx)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [WIDTH-1:0] data;
      int               len;
   } word_t;

   word_t words[$];   // words[0] is the one on A; at most one more waits
   int    pos;        // bits of words[0] already sent
   int    n_tests = 0;
   int    n_fail  = 0;
   int    cyc     = 0;
   bit    accepted;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s (cycle %0d): got 0x%0h, expected 0x%0h", tag, cyc, got, exp);
      end
   endtask

   function automatic int eff_len(input logic [LEN_W-1:0] l);
      if (l == 0 || int'(l) > WIDTH) return WIDTH;
      return int'(l);
   endfunction

   // {in_ready, A_valid, A, last, busy, bit_idx} as the stream rules predict.
   function automatic logic [5+LEN_W-1:0] model_out(input logic r);
      logic             rdy, av, a, lst;
      logic [LEN_W-1:0] idx;
      rdy = !r && (words.size() <= 1);
      av  = (words.size() > 0);
      a   = 1'b0;
      lst = 1'b0;
      idx = '0;
      if (av) begin
         a   = words[0].data[words[0].len - 1 - pos];
         idx = LEN_W'(words[0].len - 1 - pos);
         lst = (pos == words[0].len - 1);
      end
      return {rdy, av, a, lst, av, idx};
   endfunction

   // Drive one cycle's inputs, compare outputs, then advance across one edge.
   task automatic step(input logic v, input logic [WIDTH-1:0] d, input logic [LEN_W-1:0] l,
                       input logic e, input logic r);
      logic [5+LEN_W-1:0] exp_v;
      logic [5+LEN_W-1:0] got_v;
      word_t              w;
      rst          = r;
      en           = e;
      bus.in_valid = v;
      bus.in_data  = d;
      bus.in_len   = l;
      #1;
      exp_v = model_out(r);
      got_v = {bus.in_ready, A_valid, A, last, busy, bit_idx};
      check("outputs", 32'(got_v), 32'(exp_v));
      accepted = v && exp_v[5+LEN_W-1];
      @(posedge clk);
      if (r) begin
         words.delete();
         pos = 0;
      end else begin
         if (words.size() > 0 && e) begin
            pos++;
            if (pos == words[0].len) begin
               words.delete(0);
               pos = 0;
            end
         end
         if (accepted) begin
            w.data = d;
            w.len  = eff_len(l);
            words.push_back(w);
         end
      end
      @(negedge clk);
      cyc++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b1, 1'b0);
   endtask

   initial begin
      logic [WIDTH-1:0] cap;
      logic [11:0]      cap12;
      logic [WIDTH-1:0] bp_data[3];
      logic [LEN_W-1:0] bp_len[3];
      int               nvalid;
      int               nfrozen;
      int               total;
      int               n_acc;

      rst          = 1'b1;
      en           = 1'b1;
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      bus.in_len   = '0;
      pos          = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);

      // Reset state, both with rst still high and after release.
      step(1'b1, 24'h123456, 5'd4, 1'b1, 1'b1);
      idle(2);

      // Single full-width word via in_len=0.
      step(1'b1, 24'hE34EED, 5'd0, 1'b1, 1'b0);
      cap = '0;
      nvalid = 0;
      for (int i = 0; i < 24; i++) begin
         cap = {cap[WIDTH-2:0], A};
         nvalid += int'(A_valid);
         step(1'b0, '0, '0, 1'b1, 1'b0);
      end
      check("e34eed_bits", 32'(cap), 32'h00E34EED);
      check("e34eed_valid_cycles", 32'(nvalid), 32'd24);
      idle(2);

      // Back-to-back: 8'hA5 then 4'b0110, no gap between them.
      cap12 = '0;
      step(1'b1, 24'h0000A5, 5'd8, 1'b1, 1'b0);
      cap12 = {cap12[10:0], A};
      step(1'b1, 24'h000006, 5'd4, 1'b1, 1'b0);
      for (int i = 0; i < 11; i++) begin
         cap12 = {cap12[10:0], A};
         step(1'b0, '0, '0, 1'b1, 1'b0);
      end
      check("b2b_bits", 32'(cap12), 32'h00000A56);
      idle(2);

      // Stall three edges while bit 10 is on A.
      step(1'b1, 24'hE34EED, 5'd0, 1'b1, 1'b0);
      nvalid  = 0;
      nfrozen = 0;
      for (int c = 1; c <= 35; c++) begin
         nvalid  += int'(A_valid);
         nfrozen += int'(A_valid && bit_idx == 10);
         step(1'b0, '0, '0, !(c >= 14 && c <= 16), 1'b0);
      end
      check("stall_duration", 32'(nvalid), 32'd27);
      check("stall_frozen", 32'(nfrozen), 32'd4);

      // Length edge cases.
      step(1'b1, 24'hFFFFF1, 5'd1, 1'b1, 1'b0);
      check("len1_bit", {29'd0, A, A_valid, last}, 32'd7);
      idle(2);
      step(1'b1, 24'h5A5A5A, 5'd31, 1'b1, 1'b0);
      nvalid = 0;
      for (int i = 0; i < 30; i++) begin
         nvalid += int'(A_valid);
         step(1'b0, '0, '0, 1'b1, 1'b0);
      end
      check("len31_cycles", 32'(nvalid), 32'd24);

      // Reset at bit_idx 12 with a word buffered; that word must never appear.
      step(1'b1, 24'hE34EED, 5'd0, 1'b1, 1'b0);
      step(1'b1, 24'h00000F, 5'd4, 1'b1, 1'b0);
      idle(10);
      check("rst_at_idx", 32'(bit_idx), 32'd12);
      step(1'b0, '0, '0, 1'b1, 1'b1);
      nvalid = 0;
      for (int i = 0; i < 30; i++) begin
         nvalid += int'(A_valid);
         step(1'b0, '0, '0, 1'b1, 1'b0);
      end
      check("rst_no_emit", 32'(nvalid), 32'd0);

      // Backpressure: three words offered with in_valid held high.
      total = 0;
      for (int i = 0; i < 3; i++) begin
         bp_data[i] = WIDTH'($urandom);
         bp_len[i]  = LEN_W'($urandom_range(0, 31));
         total     += eff_len(bp_len[i]);
      end
      n_acc  = 0;
      nvalid = 0;
      for (int c = 0; c < 200 && n_acc < 3; c++) begin
         nvalid += int'(A_valid);
         step(1'b1, bp_data[n_acc], bp_len[n_acc], 1'b1, 1'b0);
         if (accepted) n_acc++;
      end
      check("bp_accepted", 32'(n_acc), 32'd3);
      for (int c = 0; c < 200 && words.size() > 0; c++) begin
         nvalid += int'(A_valid);
         step(1'b0, '0, '0, 1'b1, 1'b0);
      end
      check("bp_total_bits", 32'(nvalid), 32'(total));

      // Random traffic with stalls and occasional reset.
      for (int i = 0; i < 4000; i++) begin
         step(1'($urandom_range(0, 1)), WIDTH'($urandom), LEN_W'($urandom_range(0, 31)),
              ($urandom_range(0, 9) != 0), ($urandom_range(0, 199) == 0));
      end
      idle(60);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end

endmodule
